// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//   Writeback side of the register file write port. Writeback requests from
//   the execute/memory stages go into a small FIFO. The FIFO drains one entry
//   per cycle onto the register file write port. Entries that are queued but
//   not yet written are forwarded onto both read paths, so readers always see
//   the newest value for a register.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   wb_valid/wb_ready        writeback request handshake
//   wb_reg/wb_data           request destination index and data
//   hold                     suppresses draining for the current cycle
//   DstReg/DstData/WriteReg  register file write port
//   SrcReg1/SrcReg2          read indices (SrcReg1 also goes to the register file)
//   rf_data1/rf_data2        raw register file read data
//   SrcData1/SrcData2        read data after forwarding
//   count                    number of entries currently queued
module reg_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              hold,
    output logic [ADDR_W-1:0] DstReg,
    output logic [DATA_W-1:0] DstData,
    output logic              WriteReg,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2,
    output logic [CNT_W-1:0]  count
);

    logic [ADDR_W-1:0] regArr  [DEPTH];
    logic [DATA_W-1:0] dataArr [DEPTH];
    logic [DEPTH-1:0]  validArr;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic notEmpty;
    logic doEnq;
    logic doDeq;

    assign notEmpty = (count != '0);

    // While rst is asserted the outputs show the post-reset values. The stored
    // state is only cleared at the next edge.
    assign wb_ready = rst ? 1'b1 : (count != CNT_W'(DEPTH));
    assign WriteReg = !rst && notEmpty && !hold;
    assign DstReg   = (!rst && notEmpty) ? regArr[head]  : '0;
    assign DstData  = (!rst && notEmpty) ? dataArr[head] : '0;

    // Register 0 is hardwired zero. Requests to it complete the handshake,
    // but their data is dropped.
    assign doEnq = wb_valid && wb_ready && (wb_reg != '0);
    assign doDeq = WriteReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            validArr <= '0;
        end else begin
            if (doEnq) begin
                tail           <= tail + PTR_W'(1);
                validArr[tail] <= 1'b1;
            end
            if (doDeq) begin
                head           <= head + PTR_W'(1);
                validArr[head] <= 1'b0;
            end
            case ({doEnq, doDeq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The payload needs no reset because validArr/count qualify every use.
    always_ff @(posedge clk) begin
        if (!rst && doEnq) begin
            regArr[tail]  <= wb_reg;
            dataArr[tail] <= wb_data;
        end
    end

    // The scan runs from oldest (head) to youngest. A later match overrides an
    // earlier one, so the youngest pending write wins. The head entry that is
    // being written this cycle still takes part in the scan.
    always_comb begin
        SrcData1 = rf_data1;
        SrcData2 = rf_data2;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (validArr[head + PTR_W'(i)] && (SrcReg1 != '0) &&
                    (regArr[head + PTR_W'(i)] == SrcReg1))
                    SrcData1 = dataArr[head + PTR_W'(i)];
                if (validArr[head + PTR_W'(i)] && (SrcReg2 != '0) &&
                    (regArr[head + PTR_W'(i)] == SrcReg2))
                    SrcData2 = dataArr[head + PTR_W'(i)];
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
module tb_reg_writeback_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data;
    logic        hold;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic        WriteReg;
    logic [3:0]  SrcReg1, SrcReg2;
    logic [15:0] rf_data1, rf_data2;
    logic [15:0] SrcData1, SrcData2;
    logic [2:0]  count;

    int nChecks = 0;
    int nFail   = 0;

    reg_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(4), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_reg(wb_reg), .wb_data(wb_data), .hold(hold),
        .DstReg(DstReg), .DstData(DstData), .WriteReg(WriteReg),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .SrcData1(SrcData1), .SrcData2(SrcData2), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of pending writes, oldest at index 0.
    typedef struct {
        logic [3:0]  r;
        logic [15:0] d;
    } ent_t;
    ent_t mq[$];

    function automatic logic [15:0] modelFwd(input logic [3:0] s, input logic [15:0] rf);
        modelFwd = rf;
        if (s != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].r == s) begin
                    modelFwd = mq[i].d;
                    break;
                end
            end
        end
    endfunction

    // One clock: update the model with what the queue should do at the edge, then return to negedge.
    task automatic cycle();
        bit deq, enq;
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            deq = (mq.size() != 0) && !hold;
            enq = wb_valid && (mq.size() != DEPTH) && (wb_reg != 0);
            if (deq) void'(mq.pop_front());
            if (enq) mq.push_back('{r: wb_reg, d: wb_data});
        end
        @(negedge clk);
    endtask

    task automatic idleInputs();
        wb_valid = 0; wb_reg = 0; wb_data = 0; hold = 0;
        SrcReg1 = 0; SrcReg2 = 0; rf_data1 = 16'h1234; rf_data2 = 16'h5678;
    endtask

    task automatic test_reset();
        idleInputs();
        rst = 1; SrcReg1 = 4'd3; rf_data1 = 16'hC0DE;
        #1;
        nChecks++; if (WriteReg !== 1'b0) begin nFail++; $display("FAIL reset_writereg got %b want 0", WriteReg); end
        nChecks++; if (wb_ready !== 1'b1) begin nFail++; $display("FAIL reset_ready got %b want 1", wb_ready); end
        nChecks++; if (DstReg !== 4'd0 || DstData !== 16'd0) begin nFail++; $display("FAIL reset_dst got %h/%h want 0/0", DstReg, DstData); end
        nChecks++; if (SrcData1 !== 16'hC0DE) begin nFail++; $display("FAIL reset_passthru got %h want c0de", SrcData1); end
        cycle();
        rst = 0;
        #1;
        nChecks++; if (count !== 3'd0) begin nFail++; $display("FAIL reset_count got %0d want 0", count); end
    endtask

    task automatic test_single();
        idleInputs();
        wb_valid = 1; wb_reg = 4'd3; wb_data = 16'hBEEF;
        #1;
        nChecks++; if (WriteReg !== 1'b0) begin nFail++; $display("FAIL single_pre_write got %b want 0", WriteReg); end
        cycle();
        wb_valid = 0;
        #1;
        nChecks++; if (WriteReg !== 1'b1 || DstReg !== 4'd3 || DstData !== 16'hBEEF)
            begin nFail++; $display("FAIL single_write got %b/%h/%h want 1/3/beef", WriteReg, DstReg, DstData); end
        nChecks++; if (count !== 3'd1) begin nFail++; $display("FAIL single_count1 got %0d want 1", count); end
        cycle();
        nChecks++; if (count !== 3'd0 || WriteReg !== 1'b0) begin nFail++; $display("FAIL single_drained got %0d/%b want 0/0", count, WriteReg); end
    endtask

    task automatic test_fill_hold();
        idleInputs();
        hold = 1;
        for (int i = 1; i <= 4; i++) begin
            wb_valid = 1; wb_reg = 4'(i); wb_data = 16'(8'h11 * i);
            cycle();
        end
        #1;
        nChecks++; if (count !== 3'd4 || wb_ready !== 1'b0) begin nFail++; $display("FAIL fill_full got %0d/%b want 4/0", count, wb_ready); end
        wb_reg = 4'd5; wb_data = 16'h0055;
        cycle();
        nChecks++; if (count !== 3'd4) begin nFail++; $display("FAIL fill_fifth_ignored got %0d want 4", count); end
        wb_valid = 0; hold = 0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            nChecks++; if (WriteReg !== 1'b1 || DstReg !== 4'(i) || DstData !== 16'(8'h11 * i))
                begin nFail++; $display("FAIL fill_drain%0d got %b/%h/%h want 1/%h/%h", i, WriteReg, DstReg, DstData, 4'(i), 16'(8'h11 * i)); end
            cycle();
        end
        nChecks++; if (count !== 3'd0) begin nFail++; $display("FAIL fill_empty got %0d want 0", count); end
    endtask

    task automatic test_forward_same_reg();
        idleInputs();
        hold = 1; SrcReg1 = 4'd5; rf_data1 = 16'hAAAA;
        wb_valid = 1; wb_reg = 4'd5; wb_data = 16'h0100;
        cycle();
        wb_data = 16'h0200;
        #1;
        // the second request is presented but not yet enqueued
        nChecks++; if (SrcData1 !== 16'h0100) begin nFail++; $display("FAIL fwd_incoming got %h want 0100", SrcData1); end
        cycle();
        wb_valid = 0;
        #1;
        nChecks++; if (SrcData1 !== 16'h0200) begin nFail++; $display("FAIL fwd_youngest got %h want 0200", SrcData1); end
        hold = 0;
        cycle();
        nChecks++; if (SrcData1 !== 16'h0200) begin nFail++; $display("FAIL fwd_one_left got %h want 0200", SrcData1); end
        cycle();
        nChecks++; if (SrcData1 !== 16'hAAAA || count !== 3'd0) begin nFail++; $display("FAIL fwd_drained got %h/%0d want aaaa/0", SrcData1, count); end
    endtask

    task automatic test_reg_zero();
        idleInputs();
        wb_valid = 1; wb_reg = 4'd0; wb_data = 16'hFFFF; SrcReg2 = 4'd0;
        #1;
        nChecks++; if (wb_ready !== 1'b1) begin nFail++; $display("FAIL zero_ready got %b want 1", wb_ready); end
        cycle();
        wb_valid = 0;
        #1;
        nChecks++; if (count !== 3'd0 || WriteReg !== 1'b0) begin nFail++; $display("FAIL zero_discard got %0d/%b want 0/0", count, WriteReg); end
        nChecks++; if (SrcData2 !== rf_data2) begin nFail++; $display("FAIL zero_src got %h want %h", SrcData2, rf_data2); end
        cycle();
        nChecks++; if (WriteReg !== 1'b0) begin nFail++; $display("FAIL zero_never_writes got %b want 0", WriteReg); end
    endtask

    task automatic test_back_to_back();
        idleInputs();
        hold = 1;
        for (int i = 6; i <= 9; i++) begin
            wb_valid = 1; wb_reg = 4'(i); wb_data = 16'(i * 16'h0101);
            cycle();
        end
        hold = 0; wb_reg = 4'd10; wb_data = 16'h0A0A;
        #1;
        nChecks++; if (wb_ready !== 1'b0 || WriteReg !== 1'b1 || DstReg !== 4'd6)
            begin nFail++; $display("FAIL b2b_full_drain got %b/%b/%h want 0/1/6", wb_ready, WriteReg, DstReg); end
        cycle();
        #1;
        nChecks++; if (count !== 3'd3 || wb_ready !== 1'b1) begin nFail++; $display("FAIL b2b_after got %0d/%b want 3/1", count, wb_ready); end
        wb_reg = 4'd11; wb_data = 16'h0B0B;
        cycle();
        nChecks++; if (count !== 3'd3) begin nFail++; $display("FAIL b2b_simul got %0d want 3", count); end
        wb_valid = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            nChecks++; if (WriteReg !== 1'b1 || DstReg !== mq[0].r || DstData !== mq[0].d)
                begin nFail++; $display("FAIL b2b_order%0d got %h/%h want %h/%h", k, DstReg, DstData, mq[0].r, mq[0].d); end
            cycle();
        end
        // rejected reg 10 must never appear: queue must be empty now
        nChecks++; if (count !== 3'd0) begin nFail++; $display("FAIL b2b_empty got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        idleInputs();
        hold = 1;
        for (int i = 1; i <= 3; i++) begin
            wb_valid = 1; wb_reg = 4'(i + 11); wb_data = 16'(i);
            cycle();
        end
        wb_valid = 0; hold = 0; rst = 1; SrcReg1 = 4'd12; rf_data1 = 16'h7777;
        #1;
        nChecks++; if (WriteReg !== 1'b0 || SrcData1 !== 16'h7777) begin nFail++; $display("FAIL rstmid_during got %b/%h want 0/7777", WriteReg, SrcData1); end
        cycle();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            nChecks++; if (count !== 3'd0 || WriteReg !== 1'b0) begin nFail++; $display("FAIL rstmid_after%0d got %0d/%b want 0/0", k, count, WriteReg); end
            cycle();
        end
    endtask

    task automatic test_random();
        bit expWrite;
        for (int n = 0; n < 800; n++) begin
            rst      = ($urandom_range(0, 63) == 0);
            hold     = ($urandom_range(0, 3) == 0);
            wb_valid = ($urandom_range(0, 3) != 0);
            wb_reg   = 4'($urandom_range(0, 5));
            wb_data  = 16'($urandom);
            SrcReg1  = 4'($urandom_range(0, 5));
            SrcReg2  = 4'($urandom_range(0, 5));
            rf_data1 = 16'($urandom);
            rf_data2 = 16'($urandom);
            #1;
            expWrite = !rst && (mq.size() != 0) && !hold;
            nChecks++; if (WriteReg !== expWrite) begin nFail++; $display("FAIL rnd_write n=%0d got %b want %b", n, WriteReg, expWrite); end
            if (expWrite) begin
                nChecks++; if (DstReg !== mq[0].r || DstData !== mq[0].d)
                    begin nFail++; $display("FAIL rnd_dst n=%0d got %h/%h want %h/%h", n, DstReg, DstData, mq[0].r, mq[0].d); end
            end
            nChecks++; if (wb_ready !== (rst || mq.size() != DEPTH)) begin nFail++; $display("FAIL rnd_ready n=%0d got %b", n, wb_ready); end
            nChecks++; if (count !== 3'(mq.size())) begin nFail++; $display("FAIL rnd_count n=%0d got %0d want %0d", n, count, mq.size()); end
            nChecks++; if (SrcData1 !== (rst ? rf_data1 : modelFwd(SrcReg1, rf_data1)))
                begin nFail++; $display("FAIL rnd_src1 n=%0d got %h want %h", n, SrcData1, rst ? rf_data1 : modelFwd(SrcReg1, rf_data1)); end
            nChecks++; if (SrcData2 !== (rst ? rf_data2 : modelFwd(SrcReg2, rf_data2)))
                begin nFail++; $display("FAIL rnd_src2 n=%0d got %h want %h", n, SrcData2, rst ? rf_data2 : modelFwd(SrcReg2, rf_data2)); end
            cycle();
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idleInputs();
        @(negedge clk);
        test_reset();
        test_single();
        test_fill_hold();
        test_forward_same_reg();
        test_reg_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Initiator side of the register file write port. Buffers writeback requests from the execute/memory stages in a small FIFO.
- Drains one entry per cycle onto the register file's DstReg/WriteReg/DstData port.
- Forwards still-pending (queued, not yet written) values onto both read paths, so readers never see stale register file data.
- Sits between the pipeline writeback stage and the register file.

Parameters:
DEPTH, 4, number of queue entries (power of two, >=2)
ADDR_W, 4, register index width
DATA_W, 16, register data width

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
wb_valid  in  1  writeback request valid
wb_ready  out  1  queue can accept request this cycle
wb_reg  in  ADDR_W  destination register index
wb_data  in  DATA_W  destination data
hold  in  1  suppress draining this cycle
DstReg  out  ADDR_W  register file write index
DstData  out  DATA_W  register file write data
WriteReg  out  1  register file write enable
SrcReg1  in  ADDR_W  read port 1 index (also drives register file)
SrcReg2  in  ADDR_W  read port 2 index
rf_data1  in  DATA_W  raw register file read data, port 1
rf_data2  in  DATA_W  raw register file read data, port 2
SrcData1  out  DATA_W  forwarded read data, port 1
SrcData2  out  DATA_W  forwarded read data, port 2
count  out  clog2(DEPTH)+1  entries currently queued

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset: head=tail=0, count=0, all entry valid bits cleared.
  - Outputs while rst held: WriteReg=0, wb_ready=1, DstReg=0, DstData=0.
  - SrcData1/2 pass rf_data1/2 through.
- Reset mid-operation discards all pending entries; none are written.
- Handshake:
  - wb_ready = (count != DEPTH). It is not dependent on a same-cycle dequeue.
  - A transfer occurs when wb_valid && wb_ready at a clock edge.
- Register 0 is hardwired zero: a transfer with wb_reg==0 is accepted and discarded. No enqueue, count unchanged.
- Enqueue: the entry is written at tail, tail wraps modulo DEPTH, count+1.
- Drain (combinational from head):
  - WriteReg = (count!=0) && !hold.
  - DstReg/DstData = head entry when count!=0, else 0.
  - On an edge with WriteReg=1: head advances (wraps), count-1.
- Latency: a request accepted at edge N into an empty queue, with hold low, produces WriteReg=1 during cycle N+1. The register file updates at edge N+1.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. Legal at any non-full count, including count=1.
- Ordering: strict FIFO. Multiple pending writes to the same register are all issued, in order.
- Forwarding, per port:
  - SrcDataK = data of the youngest valid queued entry whose reg == SrcRegK, else rf_dataK.
  - "Youngest" means closest to tail.
  - The head entry being written this cycle still counts as queued for forwarding.
  - The incoming wb_* request is NOT forwarded until it is enqueued.
  - SrcRegK==0 always yields rf_dataK.
- Width: no arithmetic on data. Pointers are ADDR-free clog2(DEPTH) bits with natural wrap. count saturates only by the handshake rules.
- hold has no effect on enqueue or forwarding.

Test Plan:
- Reset, then single request (reg=3, data=0xBEEF) -> next cycle WriteReg=1, DstReg=3, DstData=0xBEEF; count 1->0 after that edge.
- hold=1, push reg=1..4 (data 0x11,0x22,0x33,0x44) -> count=4, wb_ready=0. A fifth push is ignored. Release hold -> writes issue 1,2,3,4 on consecutive cycles.
- hold=1, push (5,0x0100) then (5,0x0200); SrcReg1=5, rf_data1=0xAAAA -> SrcData1=0x0200. After both drain -> SrcData1=0xAAAA.
- Push reg=0 data=0xFFFF -> wb_ready=1, count stays 0, WriteReg never asserts.
- Full queue with hold=0 and wb_valid=1 -> wb_ready=0 that cycle. Next cycle count=3, wb_ready=1, enqueue and dequeue together keep count=3.
- Three entries queued, assert rst for one cycle -> count=0, WriteReg=0, no queued write ever reaches the register file.
